rup_frame_serializer: RTL and testbench



---
 rtl/rup_frame_serializer_pkg.sv | 46 ++++
 rtl/rup_frame_serializer_if.sv | 30 +++
 rtl/rup_frame_serializer_fifo.sv | 72 +++++++
 rtl/rup_frame_serializer.sv | 132 +++++++++++++
 tb/tb_rup_frame_serializer.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/rup_frame_serializer_pkg.sv
// Shared types for the rup frame serializer: snapshot payload, beat index, FSM state
// and the beat mux that turns a snapshot into its 16-bit frame beats.
package rup_frame_pkg;

  localparam int unsigned BEATS_PER_FRAME = 8;
  localparam int unsigned BEAT_W          = 16;
  localparam int unsigned HTRJ_W          = 32;
  localparam int unsigned ZTC_W           = 16;
  localparam int unsigned YU_W            = 6;

  typedef logic [2:0] beat_idx_t;

  localparam beat_idx_t FIRST_BEAT = 3'(0);
  localparam beat_idx_t LAST_BEAT  = 3'(BEATS_PER_FRAME - 1);

  typedef struct packed {
    logic [HTRJ_W-1:0] htrj1;
    logic [HTRJ_W-1:0] htrj2;
    logic [HTRJ_W-1:0] htrj3;
    logic [ZTC_W-1:0]  ztc;
    logic [YU_W-1:0]   yu;
  } snapshot_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Beat 7 parity covers every payload bit, i.e. beats 0..6 plus yu.
  function automatic logic [BEAT_W-1:0] beat_word(input snapshot_t s, input beat_idx_t idx);
    logic [BEAT_W-1:0] w;
    w = '0;
    case (idx)
      3'd0:    w = s.htrj1[31:16];
      3'd1:    w = s.htrj1[15:0];
      3'd2:    w = s.htrj2[31:16];
      3'd3:    w = s.htrj2[15:0];
      3'd4:    w = s.htrj3[31:16];
      3'd5:    w = s.htrj3[15:0];
      3'd6:    w = s.ztc;
      default: w = {^s, 9'b0, s.yu};
    endcase
    return w;
  endfunction

endpackage

// File: rtl/rup_frame_serializer_if.sv
// Handshake bundle between rup, the frame serializer and the downstream stream consumer.
interface rup_frame_serializer_if #(
  parameter int unsigned CNT_W = 8
);
  import rup_frame_pkg::*;

  logic                      in_valid;
  logic                      in_ready;
  int                        htrj [1:3];
  shortint                   ztc  [4:4];
  logic [1:3][4:3][2:2]      yu;

  logic                      out_valid;
  logic                      out_ready;
  logic [BEAT_W-1:0]         out_data;
  logic                      out_sof;
  logic                      out_eof;
  logic [CNT_W-1:0]          frame_cnt;

  modport master (
    input  in_valid, htrj, ztc, yu, out_ready,
    output in_ready, out_valid, out_data, out_sof, out_eof, frame_cnt
  );

  modport slave (
    output in_valid, htrj, ztc, yu, out_ready,
    input  in_ready, out_valid, out_data, out_sof, out_eof, frame_cnt
  );

endinterface

// File: rtl/rup_frame_serializer_fifo.sv
// Snapshot FIFO with registered full/empty/multi flags and a look-ahead of the entry
// behind the head, so the serializer can start the next frame without a bubble.
module rup_frame_fifo
  import rup_frame_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push_i,
  input  snapshot_t wdata_i,
  input  logic      pop_i,
  output snapshot_t head_o,
  output snapshot_t next_o,
  output logic      full_o,
  output logic      empty_o,
  output logic      multi_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;

  snapshot_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0] count_q, count_d;
  logic             full_q, empty_q, multi_q;
  logic             do_push, do_pop;

  assign do_push = push_i && !full_q;
  assign do_pop  = pop_i && !empty_q;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + OCC_W'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - OCC_W'(1);
    end
  end

  // Payload storage needs no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      multi_q  <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      full_q  <= (count_d == OCC_W'(DEPTH));
      empty_q <= (count_d == '0);
      multi_q <= (count_d > OCC_W'(1));
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign next_o  = mem_q[rd_ptr_q + PTR_W'(1)];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign multi_o = multi_q;

endmodule

// File: rtl/rup_frame_serializer.sv
// Serializes buffered rup snapshots into 8-beat 16-bit frames with SOF/EOF markers,
// a parity beat and a wrapping count of completed frames.
module rup_frame_serializer
  import rup_frame_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  rup_frame_serializer_if.master bus
);

  snapshot_t         in_snap, head_snap, next_snap;
  logic              fifo_full, fifo_empty, fifo_multi;
  logic              pop_c;

  state_t            state_q, state_d;
  beat_idx_t         beat_idx_q, beat_idx_d, beat_nxt;
  logic              out_valid_q, out_valid_d;
  logic [BEAT_W-1:0] out_data_q, out_data_d;
  logic              out_sof_q, out_sof_d;
  logic              out_eof_q, out_eof_d;
  logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;

  // yu packs with yu[1][4] as the MSB and yu[3][3] as the LSB.
  always_comb begin
    in_snap       = '0;
    in_snap.htrj1 = HTRJ_W'($unsigned(bus.htrj[1]));
    in_snap.htrj2 = HTRJ_W'($unsigned(bus.htrj[2]));
    in_snap.htrj3 = HTRJ_W'($unsigned(bus.htrj[3]));
    in_snap.ztc   = ZTC_W'($unsigned(bus.ztc[4]));
    in_snap.yu    = YU_W'(bus.yu);
  end

  rup_frame_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (bus.in_valid),
    .wdata_i (in_snap),
    .pop_i   (pop_c),
    .head_o  (head_snap),
    .next_o  (next_snap),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .multi_o (fifo_multi)
  );

  assign beat_nxt = beat_idx_q + 3'(1);

  always_comb begin
    state_d     = state_q;
    beat_idx_d  = beat_idx_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sof_d   = out_sof_q;
    out_eof_d   = out_eof_q;
    frame_cnt_d = frame_cnt_q;
    pop_c       = 1'b0;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d     = SEND;
          beat_idx_d  = FIRST_BEAT;
          out_valid_d = 1'b1;
          out_data_d  = beat_word(head_snap, FIRST_BEAT);
          out_sof_d   = 1'b1;
          out_eof_d   = 1'b0;
        end
      end
      SEND: begin
        if (out_valid_q && bus.out_ready) begin
          if (beat_idx_q != LAST_BEAT) begin
            beat_idx_d = beat_nxt;
            out_data_d = beat_word(head_snap, beat_nxt);
            out_sof_d  = 1'b0;
            out_eof_d  = (beat_nxt == LAST_BEAT);
          end else begin
            pop_c       = 1'b1;
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
            beat_idx_d  = FIRST_BEAT;
            out_eof_d   = 1'b0;
            // Chain straight into the entry behind the head when it is already stored.
            if (fifo_multi) begin
              out_data_d = beat_word(next_snap, FIRST_BEAT);
              out_sof_d  = 1'b1;
            end else begin
              state_d     = IDLE;
              out_valid_d = 1'b0;
              out_data_d  = '0;
              out_sof_d   = 1'b0;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      beat_idx_q  <= FIRST_BEAT;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sof_q   <= 1'b0;
      out_eof_q   <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      beat_idx_q  <= beat_idx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sof_q   <= out_sof_d;
      out_eof_q   <= out_eof_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign bus.in_ready  = !fifo_full;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sof   = out_sof_q;
  assign bus.out_eof   = out_eof_q;
  assign bus.frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_rup_frame_serializer.sv
// Directed bench for rup_frame_serializer: framing, backpressure, FIFO full,
// parity corners, asynchronous reset mid-frame and frame counter wrap.
module tb_rup_frame_serializer;

  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;

  rup_frame_serializer_if #(.CNT_W(8)) bus ();

  rup_frame_serializer #(
    .DEPTH (2),
    .CNT_W (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_snap(input logic [31:0] h1, input logic [31:0] h2, input logic [31:0] h3,
                          input logic [15:0] z, input logic [5:0] y);
    bus.htrj[1] = h1;
    bus.htrj[2] = h2;
    bus.htrj[3] = h3;
    bus.ztc[4]  = z;
    bus.yu      = y;
  endtask

  task automatic expect_beats(input string tag, input logic [15:0] w [8], input int first, input int last);
    for (int i = first; i <= last; i++) begin
      check($sformatf("%s_b%0d_valid", tag, i), 32'(bus.out_valid), 32'd1);
      check($sformatf("%s_b%0d_data", tag, i), 32'(bus.out_data), 32'(w[i]));
      check($sformatf("%s_b%0d_sof", tag, i), 32'(bus.out_sof), 32'(i == 0));
      check($sformatf("%s_b%0d_eof", tag, i), 32'(bus.out_eof), 32'(i == 7));
      tick();
    end
  endtask

  task automatic wait_sof(input string tag);
    int n;
    n = 0;
    while (!(bus.out_valid && bus.out_sof) && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_sof_seen"}, 32'(bus.out_valid && bus.out_sof), 32'd1);
  endtask

  logic [15:0] f1 [8];
  logic [15:0] f2 [8];
  logic [15:0] s1 [8];
  logic [15:0] s2 [8];
  logic [15:0] fz [8];
  logic [15:0] fo [8];
  int          timeouts;
  int          stray;

  initial begin
    n_assert = 0;
    n_fail   = 0;
    f1 = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666, 16'h7777, 16'h802A};
    f2 = '{16'hA0A1, 16'hA2A3, 16'hB0B1, 16'hB2B3, 16'hC0C1, 16'hC2C3, 16'hD0D1, 16'h0007};
    s1 = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006, 16'h0007, 16'h8001};
    s2 = '{16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0500, 16'h0600, 16'h0700, 16'h8020};
    fz = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    // 118 set payload bits is an even count, so the parity bit stays clear.
    fo = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h003F};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    set_snap(32'h0, 32'h0, 32'h0, 16'h0, 6'h0);
    repeat (3) tick();
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_out_sof", 32'(bus.out_sof), 32'd0);
    check("rst_out_eof", 32'(bus.out_eof), 32'd0);
    check("rst_frame_cnt", 32'(bus.frame_cnt), 32'd0);
    rst_n = 1'b1;
    tick();
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Single frame and first-beat latency.
    bus.out_ready = 1'b1;
    set_snap(32'h11112222, 32'h33334444, 32'h55556666, 16'h7777, 6'b101010);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    check("lat_not_yet_valid", 32'(bus.out_valid), 32'd0);
    tick();
    expect_beats("f1", f1, 0, 7);
    check("f1_frame_cnt", 32'(bus.frame_cnt), 32'd1);
    check("f1_idle_after", 32'(bus.out_valid), 32'd0);

    // Backpressure at beat 3 for five cycles.
    set_snap(32'hA0A1A2A3, 32'hB0B1B2B3, 32'hC0C1C2C3, 16'hD0D1, 6'b000111);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    wait_sof("f2");
    expect_beats("f2", f2, 0, 2);
    bus.out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp_hold%0d_valid", c), 32'(bus.out_valid), 32'd1);
      check($sformatf("bp_hold%0d_data", c), 32'(bus.out_data), 32'h0000B2B3);
      check($sformatf("bp_hold%0d_eof", c), 32'(bus.out_eof), 32'd0);
      tick();
    end
    bus.out_ready = 1'b1;
    expect_beats("f2", f2, 3, 7);
    check("f2_frame_cnt", 32'(bus.frame_cnt), 32'd2);

    // Fill the FIFO; a third snapshot must be refused.
    bus.out_ready = 1'b0;
    set_snap(32'h00010002, 32'h00030004, 32'h00050006, 16'h0007, 6'b000001);
    bus.in_valid = 1'b1;
    check("full_ready_push1", 32'(bus.in_ready), 32'd1);
    tick();
    set_snap(32'h01000200, 32'h03000400, 32'h05000600, 16'h0700, 6'b100000);
    check("full_ready_push2", 32'(bus.in_ready), 32'd1);
    tick();
    check("full_ready_low", 32'(bus.in_ready), 32'd0);
    set_snap(32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 16'hDEAD, 6'h15);
    tick();
    check("full_ready_still_low", 32'(bus.in_ready), 32'd0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    expect_beats("s1", s1, 0, 6);
    check("full_eof_ready_low", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b1;
    expect_beats("s1", s1, 7, 7);
    bus.in_valid = 1'b0;
    check("full_eof_ready_freed", 32'(bus.in_ready), 32'd1);
    expect_beats("s2", s2, 0, 7);
    check("full_no_third_frame", 32'(bus.out_valid), 32'd0);
    check("full_frame_cnt", 32'(bus.frame_cnt), 32'd4);

    // Parity corners.
    set_snap(32'h0, 32'h0, 32'h0, 16'h0, 6'h00);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    wait_sof("zero");
    expect_beats("zero", fz, 0, 7);
    set_snap(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 16'hFFFF, 6'h3F);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    wait_sof("ones");
    expect_beats("ones", fo, 0, 7);
    check("ones_frame_cnt", 32'(bus.frame_cnt), 32'd6);

    // Asynchronous reset at beat 4 with a second snapshot still buffered.
    set_snap(32'h11112222, 32'h33334444, 32'h55556666, 16'h7777, 6'b101010);
    bus.in_valid = 1'b1;
    tick();
    tick();
    bus.in_valid = 1'b0;
    wait_sof("mid");
    repeat (4) tick();
    check("mid_beat4_data", 32'(bus.out_data), 32'h00005555);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_data", 32'(bus.out_data), 32'd0);
    check("mid_rst_frame_cnt", 32'(bus.frame_cnt), 32'd0);
    tick();
    rst_n = 1'b1;
    check("mid_rel_in_ready", 32'(bus.in_ready), 32'd1);
    stray = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (bus.out_valid) stray++;
    end
    check("mid_no_stale_beats", 32'(stray), 32'd0);

    // Frame counter wrap after 256 frames.
    timeouts = 0;
    set_snap(32'h0, 32'h0, 32'h0, 16'h0, 6'h00);
    for (int f = 0; f < 255; f++) begin
      int n;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      n = 0;
      while (!(bus.out_valid && bus.out_eof) && n < 40) begin
        tick();
        n++;
      end
      if (n >= 40) timeouts++;
      tick();
    end
    check("wrap_timeouts", 32'(timeouts), 32'd0);
    check("wrap_cnt_255", 32'(bus.frame_cnt), 32'd255);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    wait_sof("wrap");
    repeat (7) tick();
    check("wrap_last_eof", 32'(bus.out_eof), 32'd1);
    check("wrap_cnt_before", 32'(bus.frame_cnt), 32'd255);
    tick();
    check("wrap_cnt_zero", 32'(bus.frame_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
